// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv sequencing slice: state encoding and
// default iteration counts.
package multdiv_pkg;

  localparam int DEF_CNT_W      = 6;
  localparam int DEF_MULT_STEPS = 16;
  localparam int DEF_DIV_STEPS  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multdiv_step_limit.sv
// Selects the last iteration index for the operation in flight and compares
// the iteration counter against it.
module multdiv_step_limit
  import multdiv_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MULT_STEPS = DEF_MULT_STEPS,
  parameter int DIV_STEPS  = DEF_DIV_STEPS
) (
  input  logic             op_is_div,
  input  logic [CNT_W-1:0] count,
  output logic             at_last,
  output logic             overrun
);

  // N = 2^CNT_W truncates to all-ones, so overrun can never fire in that case
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  logic [CNT_W-1:0] last_s;

  // terminal and overrun compares against the selected limit
  always_comb begin
    if (op_is_div) begin
      last_s = DIV_LAST;
    end else begin
      last_s = MULT_LAST;
    end
    at_last = (count == last_s);
    overrun = (count > last_s);
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM pacing one multi-cycle multiply or divide: drives the iteration
// counter, issues step strobes and a one-cycle result-ready pulse.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int MULT_STEPS = DEF_MULT_STEPS,
  parameter int DIV_STEPS  = DEF_DIV_STEPS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             divisor_zero,
  input  logic [CNT_W-1:0] count_in,
  output logic             counter_enable,
  output logic             counter_clear,
  output logic             load_operands,
  output logic             step_valid,
  output logic [CNT_W-1:0] step_index,
  output logic             op_is_div,
  output logic             busy,
  output logic             result_ready,
  output logic             exception
);

  logic [1:0] state_r;
  logic [1:0] state_nx_s;
  logic       op_is_div_r;
  logic       op_is_div_nx_s;
  logic       exc_r;
  logic       exc_nx_s;
  logic       start_s;
  logic       at_last_s;
  logic       overrun_s;

  multdiv_step_limit #(
    .CNT_W      (CNT_W),
    .MULT_STEPS (MULT_STEPS),
    .DIV_STEPS  (DIV_STEPS)
  ) u_step_limit (
    .op_is_div (op_is_div_r),
    .count     (count_in),
    .at_last   (at_last_s),
    .overrun   (overrun_s)
  );

  assign start_s = ctrl_mult | ctrl_div;

  // next-state logic; a start pulse in any busy state restarts from LOAD
  always_comb begin
    state_nx_s     = state_r;
    op_is_div_nx_s = op_is_div_r;
    exc_nx_s       = exc_r;
    if (start_s) begin
      state_nx_s = ST_LOAD;
      exc_nx_s   = 1'b0;
      if (ctrl_mult) begin
        op_is_div_nx_s = 1'b0;
      end else begin
        op_is_div_nx_s = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_LOAD: begin
          if (op_is_div_r && divisor_zero) begin
            state_nx_s = ST_DONE;
            exc_nx_s   = 1'b1;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        ST_RUN: begin
          if (overrun_s) begin
            state_nx_s = ST_DONE;
            exc_nx_s   = 1'b1;
          end else if (at_last_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        ST_DONE: begin
          state_nx_s = ST_IDLE;
          exc_nx_s   = 1'b0;
        end
        default: begin
          state_nx_s = ST_IDLE;
          exc_nx_s   = 1'b0;
        end
      endcase
    end
  end

  // state, operation and exception registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      op_is_div_r <= 1'b0;
      exc_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      op_is_div_r <= op_is_div_nx_s;
      exc_r       <= exc_nx_s;
    end
  end

  // Moore output decode; step_valid is dropped in a counter-fault cycle
  always_comb begin
    counter_clear  = (state_r == ST_IDLE) || (state_r == ST_LOAD);
    load_operands  = (state_r == ST_LOAD);
    counter_enable = (state_r == ST_RUN);
    step_valid     = (state_r == ST_RUN) && !overrun_s;
    busy           = (state_r != ST_IDLE);
    result_ready   = (state_r == ST_DONE);
    exception      = (state_r == ST_DONE) && exc_r;
    op_is_div      = op_is_div_r;
    if (step_valid) begin
      step_index = count_in;
    end else begin
      step_index = {CNT_W{1'b0}};
    end
  end

endmodule
